shift_sequencer: RTL and testbench

Multi-cycle controller that executes one barrel-shift operation per request over log2(WIDTH) stage cycles. Supported operations are logical shift right/left, arithmetic shift right and rotate right/left. Left-direction operations are built from right-direction hardware by bit-reversing the operand on entry and the result on exit. Sits between the multifunction barrel shifter top level and its requester, and provides a start/busy/done handshake.

---
 rtl/shift_sequencer_pkg.sv | 28 ++
 rtl/shift_sequencer_reverse.sv | 13 +
 rtl/shift_sequencer.sv | 131 +++++++++++++
 tb/tb_shift_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared opcodes, FSM states and opcode helpers for the shift sequencer.
package shift_sequencer_pkg;

    localparam logic [2:0] OP_SRL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STAGE = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    function automatic logic is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic is_rotate(input logic [2:0] op);
        return (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_ROL;
    endfunction

endpackage

// File: rtl/shift_sequencer_reverse.sv
// Bit-order reversal; lets left operations reuse the right-shift datapath.
module shift_sequencer_reverse #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign y[i] = a[WIDTH-1-i];
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one log-stage per cycle, with start/busy/done.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] y,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam logic [SHW-1:0] LAST = SHW'(SHW - 1);

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [2:0]       op_q, op_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   a_rev;
    logic [WIDTH-1:0]   work_rev;
    logic [WIDTH-1:0]   ext;
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   stage_sh;

    shift_sequencer_reverse #(.WIDTH(WIDTH)) u_rev_in (
        .a (a),
        .y (a_rev)
    );

    shift_sequencer_reverse #(.WIDTH(WIDTH)) u_rev_out (
        .a (work_q),
        .y (work_rev)
    );

    // Upper half supplies the bits that enter at the MSB end.
    always_comb begin
        ext      = is_rotate(op_q) ? work_q : {WIDTH{fill_q}};
        stage_sh = WIDTH'(1) << cnt_q;
        wide     = {ext, work_q} >> stage_sh;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        amt_d   = amt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        y_d     = y_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = ST_STAGE;
                    if (is_reserved(op)) begin
                        work_d = a;
                        amt_d  = '0;
                        fill_d = 1'b0;
                    end else begin
                        work_d = is_left(op) ? a_rev : a;
                        amt_d  = amt;
                        fill_d = (op == OP_SRA) & a[WIDTH-1];
                    end
                end
            end
            ST_STAGE: begin
                if (amt_q[cnt_q]) begin
                    work_d = wide[WIDTH-1:0];
                end
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                y_d     = is_left(op_q) ? work_rev : work_q;
                err_d   = is_reserved(op_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            amt_q   <= '0;
            op_q    <= '0;
            fill_q  <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign err  = err_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus randomized scoreboard bench for shift_sequencer.
module tb_shift_sequencer;

    localparam logic [2:0] SRL = 3'b000;
    localparam logic [2:0] SLL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROR = 3'b011;
    localparam logic [2:0] ROL = 3'b100;

    typedef struct packed {
        logic [7:0] y;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [2:0] amt;
    logic [7:0] y;
    logic       done;
    logic       busy;
    logic       err;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    shift_sequencer #(.WIDTH(8), .SHW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .amt   (amt),
        .y     (y),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Reference shifter, written from the operation definitions.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] v,
                                   input logic [2:0] s);
        exp_t e;
        logic [15:0] dbl;
        dbl = {v, v};
        e.err = 1'b0;
        case (o)
            SRL: e.y = v >> s;
            SLL: e.y = v << s;
            SRA: e.y = 8'($signed(v) >>> s);
            ROR: e.y = 8'(dbl >> s);
            ROL: e.y = 8'((dbl << s) >> 8);
            default: begin
                e.y   = v;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            compared++;
            assert (sb.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_done: observed y=%0h expected no done", y);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                compared++;
                assert (y === e.y) else begin
                    mismatched++;
                    $error("FAIL sb_y: observed %0h expected %0h", y, e.y);
                end
                compared++;
                assert (err === e.err) else begin
                    mismatched++;
                    $error("FAIL sb_err: observed %0b expected %0b", err, e.err);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [7:0] v,
                         input logic [2:0] s, input exp_t e);
        op    = o;
        a     = v;
        amt   = s;
        start = 1'b1;
        sb.push_back(e);
    endtask

    // Waits for done; inputs are scrambled to show they are not re-sampled.
    task automatic wait_done(output int lat, output int bcnt);
        bit seen;
        lat  = 0;
        bcnt = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            a     = 8'($urandom);
            op    = 3'($urandom);
            amt   = 3'($urandom);
            lat++;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [7:0] v, input logic [2:0] s,
                          input exp_t e);
        int lat, bcnt;
        @(negedge clk);
        issue(o, v, s, e);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_busy"}, bcnt, 4);
    endtask

    initial begin
        int lat, bcnt, dcnt;
        exp_t e;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        amt   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_y", y, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        run_op("srl", SRL, 8'hF0, 3'd3, '{y: 8'h1E, err: 1'b0});
        run_op("sll", SLL, 8'h0F, 3'd5, '{y: 8'hE0, err: 1'b0});
        run_op("sra_neg", SRA, 8'h80, 3'd7, '{y: 8'hFF, err: 1'b0});
        run_op("sra_pos", SRA, 8'h40, 3'd2, '{y: 8'h10, err: 1'b0});
        run_op("ror", ROR, 8'h0F, 3'd4, '{y: 8'hF0, err: 1'b0});
        run_op("rol", ROL, 8'h81, 3'd1, '{y: 8'h03, err: 1'b0});
        for (int i = 0; i < 5; i++) begin
            run_op("amt0", 3'(i), 8'h5A, 3'd0, '{y: 8'h5A, err: 1'b0});
        end
        chk("hold_y", y, 8'h5A);

        // Start while busy is ignored; start on the done cycle is accepted.
        @(negedge clk);
        issue(ROR, 8'h01, 3'd1, '{y: 8'h80, err: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op    = SRL;
        a     = 8'hFF;
        amt   = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("ignored_lat", lat, 2);
        issue(SRA, 8'h40, 3'd2, '{y: 8'h10, err: 1'b0});
        wait_done(lat, bcnt);
        chk("b2b_lat", lat, 5);

        // Reset in the middle of the second stage.
        @(negedge clk);
        op    = SLL;
        a     = 8'hFF;
        amt   = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_y", y, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        run_op("post_rst", SRL, 8'h08, 3'd3, '{y: 8'h01, err: 1'b0});

        run_op("reserved", 3'b111, 8'hA5, 3'd6, '{y: 8'hA5, err: 1'b1});
        chk("hold_err", err, 1);
        run_op("clr_err", SRL, 8'h81, 3'd0, '{y: 8'h81, err: 1'b0});
        chk("err_cleared", err, 0);

        for (int i = 0; i < 12; i++) begin
            logic [2:0] ro;
            logic [7:0] ra;
            logic [2:0] rs;
            ro = 3'($urandom_range(0, 5));
            ra = 8'($urandom);
            rs = 3'($urandom);
            e  = model(ro, ra, ro > ROL ? 3'd0 : rs);
            run_op("rand", ro, ra, rs, e);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
